// File: rtl/mem_sched_pkg.sv
// Shared constants for the memory command scheduler: command opcodes,
// requester indices and the read-id encoding kept in the order queue.
package mem_sched_pkg;

    localparam logic [2:0] MEMC_WR = 3'b000;
    localparam logic [2:0] MEMC_RD = 3'b001;

    localparam int NUM_REQ = 5;

    localparam logic [2:0] IDX_WB = 3'd0;
    localparam logic [2:0] IDX_WR = 3'd1;
    localparam logic [2:0] IDX_WC = 3'd2;
    localparam logic [2:0] IDX_RR = 3'd3;
    localparam logic [2:0] IDX_RC = 3'd4;

    localparam logic RID_RR = 1'b0;
    localparam logic RID_RC = 1'b1;

    // Round-robin successor of a requester index, wrapping rc back to wb.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx == IDX_RC) ? IDX_WB : idx + 3'd1;
    endfunction

endpackage

// File: rtl/mem_sched_ordq.sv
// Read-order queue: remembers which read requester issued each outstanding
// read so in-order returns can be steered back. Push while full is accepted
// only when a pop happens in the same cycle; pop while empty is ignored.
module mem_sched_ordq #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       din,
    input  logic                       pop,
    output logic                       dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign dout    = mem[rptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage write; entries need no reset because cnt gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_sched.sv
// Memory command scheduler: round-robin arbitration of three writers and two
// readers onto the single memory-controller command/write port, with
// in-order read data routed back through the read-order queue.
module mem_sched
    import mem_sched_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 512,
    parameter int RDQ_DEPTH = 16
) (
    input  logic                  eclk,
    input  logic                  rstb,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  wb_ready,
    input  logic                  wr_valid,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  wr_ready,
    input  logic                  wc_valid,
    input  logic [ADDR_W-1:0]     wc_addr,
    input  logic [DATA_W-1:0]     wc_data,
    output logic                  wc_ready,
    input  logic                  rr_valid,
    input  logic [ADDR_W-1:0]     rr_addr,
    output logic                  rr_ready,
    output logic [DATA_W-1:0]     rr_rdata,
    output logic                  rr_rvalid,
    input  logic                  rc_valid,
    input  logic [ADDR_W-1:0]     rc_addr,
    output logic                  rc_ready,
    output logic [DATA_W-1:0]     rc_rdata,
    output logic                  rc_rvalid,
    input  logic                  memc_cmd_full,
    output logic                  memc_cmd_en,
    output logic [2:0]            memc_cmd_instr,
    output logic [5:0]            memc_cmd_bl,
    output logic [ADDR_W-1:0]     memc_cmd_addr,
    input  logic                  memc_wr_full,
    output logic                  memc_wr_en,
    output logic                  memc_wr_end,
    output logic [DATA_W/8-1:0]   memc_wr_mask,
    output logic [DATA_W-1:0]     memc_wr_data,
    output logic                  memc_rd_en,
    input  logic [DATA_W-1:0]     memc_rd_data,
    input  logic                  memc_rd_empty,
    output logic                  idle,
    output logic                  err_rd_orphan
);

    localparam int CW = $clog2(RDQ_DEPTH) + 1;

    logic [NUM_REQ-1:0] req_valid;
    logic [7:0]         elig;
    logic [NUM_REQ-1:0] gnt;
    logic [2:0]         gnt_idx;
    logic               gnt_any;
    logic [3:0]         cand;
    logic [2:0]         rr_ptr;
    logic               is_rd;
    logic               is_wr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               wr_ok;
    logic               rd_ok;
    logic               rd_hit;
    logic               q_head;
    logic               q_empty;
    logic               q_full;
    logic [CW-1:0]      q_count;

    assign req_valid = {rc_valid, rr_valid, wc_valid, wr_valid, wb_valid};

    // A return popping the queue this cycle frees a slot for a read granted
    // in the same cycle, so a full queue does not block reads then.
    assign memc_rd_en = !memc_rd_empty;
    assign rd_hit     = memc_rd_en && !q_empty;
    assign wr_ok      = !memc_cmd_full && !memc_wr_full;
    assign rd_ok      = !memc_cmd_full && (!q_full || rd_hit);

    // Per-requester eligibility, padded to 8 entries for 3-bit indexing.
    always_comb begin
        elig         = '0;
        elig[IDX_WB] = wb_valid && wr_ok;
        elig[IDX_WR] = wr_valid && wr_ok;
        elig[IDX_WC] = wc_valid && wr_ok;
        elig[IDX_RR] = rr_valid && rd_ok;
        elig[IDX_RC] = rc_valid && rd_ok;
    end

    // First eligible requester at or after the round-robin pointer.
    always_comb begin
        gnt     = '0;
        gnt_idx = rr_ptr;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!gnt_any && elig[cand[2:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[2:0];
            end
        end
        if (rstb) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign wb_ready = gnt[IDX_WB];
    assign wr_ready = gnt[IDX_WR];
    assign wc_ready = gnt[IDX_WC];
    assign rr_ready = gnt[IDX_RR];
    assign rc_ready = gnt[IDX_RC];

    assign is_rd = gnt_any && ((gnt_idx == IDX_RR) || (gnt_idx == IDX_RC));
    assign is_wr = gnt_any && !is_rd;

    // Address/data of the granted requester.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        case (gnt_idx)
            IDX_WB: begin sel_addr = wb_addr; sel_data = wb_data; end
            IDX_WR: begin sel_addr = wr_addr; sel_data = wr_data; end
            IDX_WC: begin sel_addr = wc_addr; sel_data = wc_data; end
            IDX_RR: sel_addr = rr_addr;
            IDX_RC: sel_addr = rc_addr;
            default: ;
        endcase
    end

    mem_sched_ordq #(
        .DEPTH (RDQ_DEPTH)
    ) u_ordq (
        .clk   (eclk),
        .rst   (rstb),
        .push  (is_rd),
        .din   ((gnt_idx == IDX_RC) ? RID_RC : RID_RR),
        .pop   (rd_hit),
        .dout  (q_head),
        .empty (q_empty),
        .full  (q_full),
        .count (q_count)
    );

    assign memc_cmd_bl  = 6'd0;
    assign memc_wr_mask = '0;

    // Register the granted command one cycle after the handshake.
    always_ff @(posedge eclk) begin
        if (rstb) begin
            rr_ptr         <= IDX_WB;
            memc_cmd_en    <= 1'b0;
            memc_cmd_instr <= '0;
            memc_cmd_addr  <= '0;
            memc_wr_en     <= 1'b0;
            memc_wr_end    <= 1'b0;
            memc_wr_data   <= '0;
        end else begin
            memc_cmd_en <= gnt_any;
            memc_wr_en  <= is_wr;
            memc_wr_end <= is_wr;
            if (gnt_any) begin
                memc_cmd_instr <= is_rd ? MEMC_RD : MEMC_WR;
                memc_cmd_addr  <= sel_addr;
                rr_ptr         <= next_idx(gnt_idx);
            end
            if (is_wr) begin
                memc_wr_data <= sel_data;
            end
        end
    end

    // Steer popped read data to the requester at the head of the order queue.
    always_ff @(posedge eclk) begin
        if (rstb) begin
            rr_rvalid     <= 1'b0;
            rc_rvalid     <= 1'b0;
            rr_rdata      <= '0;
            rc_rdata      <= '0;
            err_rd_orphan <= 1'b0;
        end else begin
            rr_rvalid <= rd_hit && (q_head == RID_RR);
            rc_rvalid <= rd_hit && (q_head == RID_RC);
            if (rd_hit && (q_head == RID_RR)) begin
                rr_rdata <= memc_rd_data;
            end
            if (rd_hit && (q_head == RID_RC)) begin
                rc_rdata <= memc_rd_data;
            end
            if (memc_rd_en && q_empty) begin
                err_rd_orphan <= 1'b1;
            end
        end
    end

    assign idle = (q_count == '0) && !memc_cmd_en && !(|req_valid);

endmodule

// File: tb/tb_mem_sched.sv
// Scenario bench for mem_sched: a small arbitration model predicts grants,
// expected commands and read returns are queued at stimulus time and
// compared when the DUT presents them.
module tb_mem_sched;

    logic         eclk;
    logic         rstb;
    logic         wb_valid, wr_valid, wc_valid, rr_valid, rc_valid;
    logic [27:0]  wb_addr, wr_addr, wc_addr, rr_addr, rc_addr;
    logic [511:0] wb_data, wr_data, wc_data;
    logic         wb_ready, wr_ready, wc_ready, rr_ready, rc_ready;
    logic [511:0] rr_rdata, rc_rdata;
    logic         rr_rvalid, rc_rvalid;
    logic         memc_cmd_full, memc_cmd_en;
    logic [2:0]   memc_cmd_instr;
    logic [5:0]   memc_cmd_bl;
    logic [27:0]  memc_cmd_addr;
    logic         memc_wr_full, memc_wr_en, memc_wr_end;
    logic [63:0]  memc_wr_mask;
    logic [511:0] memc_wr_data;
    logic         memc_rd_en;
    logic [511:0] memc_rd_data;
    logic         memc_rd_empty;
    logic         idle, err_rd_orphan;
    logic [4:0]   rdy_vec;

    typedef struct {
        logic [2:0]   instr;
        logic [27:0]  addr;
        logic [511:0] data;
        logic         wr;
    } cmd_t;

    typedef struct {
        logic         id;
        logic [511:0] data;
    } ret_t;

    cmd_t         exp_cmd[$];
    ret_t         exp_ret[$];
    logic         exp_rid[$];
    logic [27:0]  tb_addr[5];
    logic [511:0] tb_data[3];
    int           model_ptr;
    int           model_cnt;
    int           checks;
    int           errors;

    mem_sched dut (
        .eclk(eclk), .rstb(rstb),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .wc_valid(wc_valid), .wc_addr(wc_addr), .wc_data(wc_data), .wc_ready(wc_ready),
        .rr_valid(rr_valid), .rr_addr(rr_addr), .rr_ready(rr_ready),
        .rr_rdata(rr_rdata), .rr_rvalid(rr_rvalid),
        .rc_valid(rc_valid), .rc_addr(rc_addr), .rc_ready(rc_ready),
        .rc_rdata(rc_rdata), .rc_rvalid(rc_rvalid),
        .memc_cmd_full(memc_cmd_full), .memc_cmd_en(memc_cmd_en),
        .memc_cmd_instr(memc_cmd_instr), .memc_cmd_bl(memc_cmd_bl),
        .memc_cmd_addr(memc_cmd_addr), .memc_wr_full(memc_wr_full),
        .memc_wr_en(memc_wr_en), .memc_wr_end(memc_wr_end),
        .memc_wr_mask(memc_wr_mask), .memc_wr_data(memc_wr_data),
        .memc_rd_en(memc_rd_en), .memc_rd_data(memc_rd_data),
        .memc_rd_empty(memc_rd_empty), .idle(idle), .err_rd_orphan(err_rd_orphan)
    );

    assign rdy_vec = {rc_ready, rr_ready, wc_ready, wr_ready, wb_ready};

    initial eclk = 1'b0;
    always #5 eclk = ~eclk;

    function automatic int predict(int ptr, logic [4:0] v, logic cf, logic wf,
                                   int cnt, logic hit);
        int   i;
        logic el;
        for (int k = 0; k < 5; k++) begin
            i = (ptr + k) % 5;
            if (i < 3) el = v[i] && !cf && !wf;
            else       el = v[i] && !cf && (cnt < 16 || hit);
            if (el) return i;
        end
        return -1;
    endfunction

    function automatic logic [4:0] onehot(int i);
        if (i < 0) return 5'b0;
        return 5'(1) << i;
    endfunction

    // One clock: compare what the DUT registered at this edge against the
    // scoreboard, then drive the next inputs and update the model.
    task automatic drive_cycle(input logic [4:0] v, input logic cf, input logic wf,
                               input logic re, input logic [511:0] rdat,
                               output int idx);
        cmd_t e;
        ret_t r;
        logic exp_en;
        logic [1:0] want_rv;
        logic hit;
        @(posedge eclk);
        #1;
        exp_en = (exp_cmd.size() > 0);
        checks++;
        if (memc_cmd_en !== exp_en) begin
            errors++;
            $display("FAIL cmd_en got %0b want %0b", memc_cmd_en, exp_en);
        end
        if (exp_en) begin
            e = exp_cmd.pop_front();
            checks++;
            if (memc_cmd_instr !== e.instr || memc_cmd_addr !== e.addr ||
                memc_wr_en !== e.wr || memc_wr_end !== e.wr ||
                (e.wr && memc_wr_data !== e.data)) begin
                errors++;
                $display("FAIL cmd_fields got instr=%0h addr=%0h wr_en=%0b wr_end=%0b data=%0h want instr=%0h addr=%0h wr=%0b data=%0h",
                         memc_cmd_instr, memc_cmd_addr, memc_wr_en, memc_wr_end,
                         memc_wr_data[63:0], e.instr, e.addr, e.wr, e.data[63:0]);
            end
        end
        want_rv = 2'b00;
        if (exp_ret.size() > 0) begin
            r = exp_ret.pop_front();
            want_rv = r.id ? 2'b10 : 2'b01;
            checks++;
            if ((r.id ? rc_rdata : rr_rdata) !== r.data) begin
                errors++;
                $display("FAIL rdata id=%0b got %0h want %0h", r.id,
                         r.id ? rc_rdata[63:0] : rr_rdata[63:0], r.data[63:0]);
            end
        end
        checks++;
        if ({rc_rvalid, rr_rvalid} !== want_rv) begin
            errors++;
            $display("FAIL rvalid got %b want %b", {rc_rvalid, rr_rvalid}, want_rv);
        end

        {rc_valid, rr_valid, wc_valid, wr_valid, wb_valid} = v;
        wb_addr = tb_addr[0]; wr_addr = tb_addr[1]; wc_addr = tb_addr[2];
        rr_addr = tb_addr[3]; rc_addr = tb_addr[4];
        wb_data = tb_data[0]; wr_data = tb_data[1]; wc_data = tb_data[2];
        memc_cmd_full = cf;
        memc_wr_full  = wf;
        memc_rd_empty = !re;
        memc_rd_data  = rdat;

        hit = re && (exp_rid.size() > 0);
        idx = predict(model_ptr, v, cf, wf, model_cnt, hit);
        if (hit) begin
            r.id   = exp_rid.pop_front();
            r.data = rdat;
            exp_ret.push_back(r);
            model_cnt--;
        end
        if (idx >= 0) begin
            e.instr = (idx >= 3) ? 3'b001 : 3'b000;
            e.addr  = tb_addr[idx];
            e.wr    = (idx < 3);
            e.data  = (idx < 3) ? tb_data[idx] : '0;
            exp_cmd.push_back(e);
            if (idx >= 3) begin
                exp_rid.push_back(idx == 4);
                model_cnt++;
            end
            model_ptr = (idx + 1) % 5;
        end
        #1;
    endtask

    task automatic apply_reset();
        @(posedge eclk);
        #1;
        rstb = 1'b1;
        {rc_valid, rr_valid, wc_valid, wr_valid, wb_valid} = '0;
        memc_cmd_full = 1'b0;
        memc_wr_full  = 1'b0;
        memc_rd_empty = 1'b1;
        @(posedge eclk);
        #1;
        rstb = 1'b0;
        exp_cmd.delete();
        exp_ret.delete();
        exp_rid.delete();
        model_ptr = 0;
        model_cnt = 0;
        #1;
    endtask

    task automatic drain_reads(input int base);
        int idx;
        logic [31:0] w;
        for (int k = 0; k < 40 && exp_rid.size() > 0; k++) begin
            w = 32'(base + k);
            drive_cycle(5'b0, 1'b0, 1'b0, 1'b1, {16{w}}, idx);
        end
        drive_cycle(5'b0, 1'b0, 1'b0, 1'b0, '0, idx);
        drive_cycle(5'b0, 1'b0, 1'b0, 1'b0, '0, idx);
    endtask

    task automatic test_reset();
        @(posedge eclk);
        #1;
        rstb = 1'b1;
        {rc_valid, rr_valid, wc_valid, wr_valid, wb_valid} = '1;
        #1;
        checks++;
        if (rdy_vec !== 5'b0) begin
            errors++;
            $display("FAIL reset_ready got %b want 00000", rdy_vec);
        end
        apply_reset();
        checks++;
        if (memc_cmd_en !== 1'b0 || memc_wr_en !== 1'b0 || memc_wr_end !== 1'b0 ||
            memc_cmd_instr !== 3'b0 || memc_cmd_addr !== 28'b0 || memc_wr_data !== '0) begin
            errors++;
            $display("FAIL reset_cmd got en=%0b wr_en=%0b instr=%0h addr=%0h want all zero",
                     memc_cmd_en, memc_wr_en, memc_cmd_instr, memc_cmd_addr);
        end
        checks++;
        if (rr_rvalid !== 1'b0 || rc_rvalid !== 1'b0 || rr_rdata !== '0 || rc_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata got rv=%b want 00", {rc_rvalid, rr_rvalid});
        end
        checks++;
        if (idle !== 1'b1 || err_rd_orphan !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got idle=%0b err=%0b want idle=1 err=0", idle, err_rd_orphan);
        end
        checks++;
        if (memc_cmd_bl !== 6'd0 || memc_wr_mask !== '0 || memc_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL const_out got bl=%0h rd_en=%0b want bl=0 rd_en=0", memc_cmd_bl, memc_rd_en);
        end
    endtask

    task automatic test_rotation();
        int idx;
        for (int i = 0; i < 5; i++) tb_addr[i] = 28'h200 + 28'(i);
        for (int i = 0; i < 3; i++) tb_data[i] = {16{32'hCAFE0000 + 32'(i)}};
        for (int k = 0; k < 10; k++) begin
            drive_cycle(5'b11111, 1'b0, 1'b0, 1'b0, '0, idx);
            checks++;
            if (rdy_vec !== onehot(k % 5)) begin
                errors++;
                $display("FAIL rotation k=%0d got %b want %b", k, rdy_vec, onehot(k % 5));
            end
        end
        drive_cycle(5'b0, 1'b0, 1'b0, 1'b0, '0, idx);
        checks++;
        if (idle !== 1'b0) begin
            errors++;
            $display("FAIL rotation_idle got %0b want 0 with reads outstanding", idle);
        end
    endtask

    task automatic test_single_write();
        int idx;
        tb_addr[0] = 28'h100;
        tb_data[0] = {64{8'hA5}};
        drive_cycle(5'b00001, 1'b0, 1'b0, 1'b0, '0, idx);
        checks++;
        if (rdy_vec !== 5'b00001) begin
            errors++;
            $display("FAIL single_write_ready got %b want 00001", rdy_vec);
        end
        drive_cycle(5'b0, 1'b0, 1'b0, 1'b0, '0, idx);
        checks++;
        if (memc_cmd_en !== 1'b1 || memc_cmd_addr !== 28'h100 || memc_wr_data !== {64{8'hA5}}) begin
            errors++;
            $display("FAIL single_write_cmd got en=%0b addr=%0h want en=1 addr=100",
                     memc_cmd_en, memc_cmd_addr);
        end
    endtask

    task automatic test_read_order();
        int idx;
        drain_reads(32'h0BAD0000);
        tb_addr[3] = 28'h10;
        drive_cycle(5'b01000, 1'b0, 1'b0, 1'b0, '0, idx);
        checks++;
        if (rdy_vec !== 5'b01000) begin
            errors++;
            $display("FAIL read_grant0 got %b want 01000", rdy_vec);
        end
        tb_addr[4] = 28'h20;
        drive_cycle(5'b10000, 1'b0, 1'b0, 1'b0, '0, idx);
        checks++;
        if (rdy_vec !== 5'b10000) begin
            errors++;
            $display("FAIL read_grant1 got %b want 10000", rdy_vec);
        end
        tb_addr[3] = 28'h30;
        drive_cycle(5'b01000, 1'b0, 1'b0, 1'b0, '0, idx);
        checks++;
        if (rdy_vec !== 5'b01000) begin
            errors++;
            $display("FAIL read_grant2 got %b want 01000", rdy_vec);
        end
        drive_cycle(5'b0, 1'b0, 1'b0, 1'b1, {16{32'hD0D0D0D0}}, idx);
        drive_cycle(5'b0, 1'b0, 1'b0, 1'b1, {16{32'hD1D1D1D1}}, idx);
        checks++;
        if (rr_rvalid !== 1'b1 || rr_rdata !== {16{32'hD0D0D0D0}}) begin
            errors++;
            $display("FAIL read_ret0 got rv=%0b data=%0h want rv=1 data=d0d0d0d0", rr_rvalid, rr_rdata[31:0]);
        end
        drive_cycle(5'b0, 1'b0, 1'b0, 1'b1, {16{32'hD2D2D2D2}}, idx);
        drain_reads(32'h0);
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL read_idle got %0b want 1", idle);
        end
    endtask

    task automatic test_full_outstanding();
        int idx;
        for (int k = 0; k < 40 && model_cnt < 16; k++) begin
            drive_cycle(5'b11000, 1'b0, 1'b0, 1'b0, '0, idx);
            checks++;
            if (rdy_vec !== onehot(idx)) begin
                errors++;
                $display("FAIL fill_grant got %b want %b", rdy_vec, onehot(idx));
            end
        end
        for (int k = 0; k < 6; k++) begin
            drive_cycle(5'b11111, 1'b0, 1'b0, 1'b0, '0, idx);
            checks++;
            if (rdy_vec[4:3] !== 2'b00 || rdy_vec !== onehot(idx) || idx < 0) begin
                errors++;
                $display("FAIL full_block got %b want %b", rdy_vec, onehot(idx));
            end
        end
        drive_cycle(5'b01000, 1'b0, 1'b0, 1'b1, {16{32'hF00D0001}}, idx);
        checks++;
        if (rr_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_swap got rr_ready=%0b want 1", rr_ready);
        end
        drive_cycle(5'b01000, 1'b0, 1'b0, 1'b0, '0, idx);
        checks++;
        if (rr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold got rr_ready=%0b want 0", rr_ready);
        end
        drain_reads(32'h51000000);
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL full_idle got %0b want 1", idle);
        end
    endtask

    task automatic test_cmd_full();
        int idx;
        int held;
        drive_cycle(5'b11111, 1'b0, 1'b0, 1'b0, '0, idx);
        held = model_ptr;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(5'b11111, 1'b1, 1'b0, 1'b0, '0, idx);
            checks++;
            if (rdy_vec !== 5'b0) begin
                errors++;
                $display("FAIL cmd_full_ready k=%0d got %b want 00000", k, rdy_vec);
            end
        end
        drive_cycle(5'b11111, 1'b0, 1'b0, 1'b0, '0, idx);
        checks++;
        if (rdy_vec !== onehot(held)) begin
            errors++;
            $display("FAIL cmd_full_resume got %b want %b", rdy_vec, onehot(held));
        end
        for (int k = 0; k < 2; k++) begin
            drive_cycle(5'b11111, 1'b0, 1'b1, 1'b0, '0, idx);
            checks++;
            if (rdy_vec[2:0] !== 3'b0 || rdy_vec !== onehot(idx)) begin
                errors++;
                $display("FAIL wr_full got %b want %b", rdy_vec, onehot(idx));
            end
        end
        drain_reads(32'h77000000);
    endtask

    task automatic test_orphan();
        int idx;
        drive_cycle(5'b0, 1'b0, 1'b0, 1'b1, {16{32'hDEADBEEF}}, idx);
        drive_cycle(5'b0, 1'b0, 1'b0, 1'b0, '0, idx);
        checks++;
        if (err_rd_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_set got %0b want 1", err_rd_orphan);
        end
        for (int k = 0; k < 3; k++) drive_cycle(5'b0, 1'b0, 1'b0, 1'b0, '0, idx);
        checks++;
        if (err_rd_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_sticky got %0b want 1", err_rd_orphan);
        end
        apply_reset();
        checks++;
        if (err_rd_orphan !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL orphan_clear got err=%0b idle=%0b want err=0 idle=1", err_rd_orphan, idle);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_ptr = 0;
        model_cnt = 0;
        rstb = 1'b1;
        {rc_valid, rr_valid, wc_valid, wr_valid, wb_valid} = '0;
        wb_addr = '0; wr_addr = '0; wc_addr = '0; rr_addr = '0; rc_addr = '0;
        wb_data = '0; wr_data = '0; wc_data = '0;
        memc_cmd_full = 1'b0;
        memc_wr_full  = 1'b0;
        memc_rd_empty = 1'b1;
        memc_rd_data  = '0;
        for (int i = 0; i < 5; i++) tb_addr[i] = '0;
        for (int i = 0; i < 3; i++) tb_data[i] = '0;

        test_reset();
        test_rotation();
        test_single_write();
        test_read_order();
        test_full_outstanding();
        test_cmd_full();
        test_orphan();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_sched.md
# mem_sched

Memory command scheduler sharing the single memory-controller port among the three write requesters (blake2b, radix, collision) and two read requesters (radix, collision). It round-robin arbitrates single-beat 512-bit requests onto the `memc_*` command/write interface and routes in-order read returns back to the issuing requester through a read-order queue. It replaces direct requester-to-`memc` wiring and exposes an `idle` flag that the stage sequencer uses to gate stage transitions.

## Interface
- `ADDR_W`, 28: memory word address width; equals `memc_cmd_addr` width.
- `DATA_W`, 512: data width.
- `RDQ_DEPTH`, 16: maximum number of outstanding reads; power of two.
- `eclk`  in  1  clock.
- `rstb`  in  1  reset; synchronous, active-high.
- `wb_valid`/`wr_valid`/`wc_valid`  in  1 each  write requests from blake2b, radix and collision.
- `wb_addr`/`wr_addr`/`wc_addr`  in  ADDR_W each  write addresses.
- `wb_data`/`wr_data`/`wc_data`  in  DATA_W each  write data.
- `wb_ready`/`wr_ready`/`wc_ready`  out  1 each  write grants.
- `rr_valid`/`rc_valid`  in  1 each  read requests from radix and collision.
- `rr_addr`/`rc_addr`  in  ADDR_W each  read addresses.
- `rr_ready`/`rc_ready`  out  1 each  read grants.
- `rr_rdata`/`rc_rdata`  out  DATA_W each  returned read data.
- `rr_rvalid`/`rc_rvalid`  out  1 each  read-data strobes.
- `memc_cmd_full`  in  1  command FIFO full; provides at least 1 entry of slack.
- `memc_cmd_en`  out  1  command strobe.
- `memc_cmd_instr`  out  3  command type: 3'b000 = write, 3'b001 = read.
- `memc_cmd_bl`  out  6  burst length; constant 6'd0 (one beat).
- `memc_cmd_addr`  out  ADDR_W  command address.
- `memc_wr_full`  in  1  write-data FIFO full.
- `memc_wr_en`  out  1  write-data strobe.
- `memc_wr_end`  out  1  last write beat.
- `memc_wr_mask`  out  DATA_W/8  byte mask; constant 0 (write all bytes).
- `memc_wr_data`  out  DATA_W  write data.
- `memc_rd_en`  out  1  read-data pop.
- `memc_rd_data`  in  DATA_W  read data.
- `memc_rd_empty`  in  1  read-data FIFO empty.
- `idle`  out  1  no command in flight and no outstanding reads.
- `err_rd_orphan`  out  1  sticky: read data arrived while the order queue was empty.

## Operation
- Requester index order: 0 = wb, 1 = wr, 2 = wc, 3 = rr, 4 = rc. A 3-bit round-robin pointer `rr_ptr` ranges 0..4.
- Eligibility:
  - A write requester is eligible when its `valid` is high, `!memc_cmd_full` and `!memc_wr_full`.
  - A read requester is eligible when its `valid` is high, `!memc_cmd_full` and the outstanding count is below RDQ_DEPTH.
- Grant selection: the first eligible index at or after `rr_ptr`, wrapping 4→0. At most one `*_ready` is high per cycle, and it is combinational from the current inputs and state. A handshake is `valid && ready`.
- On a handshake at index i, `rr_ptr` becomes (i+1) mod 5. With no handshake, `rr_ptr` holds.
- Write grant: next cycle `memc_cmd_en` = 1, `memc_cmd_instr` = 000, `memc_cmd_addr` = the requester address, `memc_wr_en` = `memc_wr_end` = 1, `memc_wr_data` = the requester data.
- Read grant: next cycle `memc_cmd_en` = 1, `memc_cmd_instr` = 001, `memc_cmd_addr` = the requester address, `memc_wr_en` = 0.
  - At the grant cycle, the requester id (0 = rr, 1 = rc) is pushed into the order queue.
- Read return:
  - `memc_rd_en` = `!memc_rd_empty` (combinational).
  - On a pop, the queue head is popped and the data is registered onto the matching `*_rdata`, with its `*_rvalid` high for exactly one cycle.
  - If a pop occurs with the queue empty, the data is dropped and `err_rd_orphan` is set until reset.
- Outstanding count: increments on a read grant and decrements on a return. A simultaneous grant and return leaves the count unchanged. The count never exceeds RDQ_DEPTH.
- `idle` = (outstanding count == 0) && !`memc_cmd_en` && no `*_valid` high.

## Timing
- Reset (`rstb` = 1 at a clock edge) sets:
  - all strobes (`*_ready` forced 0 during reset, `*_rvalid`, `memc_cmd_en`, `memc_wr_en`, `memc_wr_end`) to 0;
  - `memc_cmd_instr`, `memc_cmd_addr`, `memc_wr_data` and `*_rdata` to 0;
  - `rr_ptr` = 0, the order queue empty, the outstanding count 0, `err_rd_orphan` = 0, `idle` = 1.
- Reset mid-operation discards queued read ids. Returns after reset count as orphans; a system reset of the controller is required alongside.
- Latency: handshake → `memc_cmd_en` = 1 cycle; `memc_rd_empty` low → `*_rvalid` = 1 cycle.
- Throughput: 1 command per cycle sustained while eligible.
- `memc_cmd_full` or `memc_wr_full` rising drops all affected `*_ready` in the same cycle. The command already registered still issues, consuming the 1-entry slack.

## Structure
- Package `mem_sched_pkg`: `MEMC_WR` = 3'b000, `MEMC_RD` = 3'b001, requester index constants 0..4, `NUM_REQ` = 5, read-id encoding.
- Sub-module `mem_sched_ordq`: synchronous FIFO, 1-bit wide, RDQ_DEPTH deep, with push, pop, empty, full and count outputs. Simultaneous push and pop are legal when empty or full.

## Test plan
- Single write `wb_addr` = 0x100, data = 0xA5…: `wb_ready` same cycle; next cycle `memc_cmd_en` = 1, instr 000, addr 0x100, `memc_wr_en` = `memc_wr_end` = 1, data matches.
- All five valid continuously, no backpressure: grants rotate wb, wr, wc, rr, rc, wb…, one per cycle; 5 commands in 5 cycles.
- Reads rr@0x10, rc@0x20, rr@0x30, returns D0, D1, D2: `rr_rvalid` with D0, `rc_rvalid` with D1, `rr_rvalid` with D2, each 1 cycle after its pop.
- 16 reads outstanding with no returns: `rr_ready` = `rc_ready` = 0 while writes are still granted. A return plus a read request in the same cycle grants the read and keeps the count at 16.
- `memc_cmd_full` = 1 for 4 cycles with all valid: no `*_ready`, no new commands after the in-flight one; resumes at the held `rr_ptr` on deassert.
- `memc_rd_empty` = 0 with empty queue: `err_rd_orphan` = 1 until `rstb` pulse; `idle` = 1 after reset.
